// File: rtl/lcd_hd44780_reader.sv
// rtl/lcd_hd44780_reader.sv - HD44780 8-bit bus read engine (optional busy polling via LCD_READER_BUSY_POLL_EN)
module lcd_hd44780_reader #(
   parameter int T_SETUP   = 3,
   parameter int T_EN_HIGH = 15,
   parameter int T_EN_LOW  = 15,
   parameter int MAX_POLLS = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rd_req,
   input  logic       rd_rs,
   output logic       rd_ready,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic       rd_busy_flag,
   output logic [6:0] rd_addr,
   output logic       rd_timeout,
   output logic       lcd_en,
   output logic       lcd_rw,
   output logic       lcd_rs,
   output logic       lcd_data_oe,
   input  logic [7:0] lcd_data_in
);

   localparam int T_MAX0 = (T_SETUP > T_EN_HIGH) ? T_SETUP : T_EN_HIGH;
   localparam int T_MAX  = (T_MAX0 > T_EN_LOW) ? T_MAX0 : T_EN_LOW;
   localparam int CNT_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] LD_EN_HIGH = CNT_W'(T_EN_HIGH - 1);
   localparam logic [CNT_W-1:0] LD_EN_LOW  = CNT_W'(T_EN_LOW - 1);

   // A zero-length phase would break the down-counter timing
   if (T_SETUP < 1 || T_EN_HIGH < 1 || T_EN_LOW < 1 || MAX_POLLS < 1) begin : g_param_check
      $error("lcd_hd44780_reader: all timing parameters and MAX_POLLS must be >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_EN_HIGH,
      S_HOLD,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       sample_q, sample_d;
   logic             lcd_en_q, lcd_en_d;
   logic             lcd_rw_q, lcd_rw_d;
   logic             lcd_rs_q, lcd_rs_d;
   logic             lcd_data_oe_q, lcd_data_oe_d;
   logic             rd_ready_q, rd_ready_d;
   logic             rd_valid_q, rd_valid_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             rd_busy_flag_q, rd_busy_flag_d;
   logic [6:0]       rd_addr_q, rd_addr_d;
   logic             rd_timeout_q, rd_timeout_d;
   logic             poll_again;

`ifdef LCD_READER_BUSY_POLL_EN
   localparam int PW = $clog2(MAX_POLLS + 1);
   logic [PW-1:0] polls_q, polls_d;

   // Busy-flag reads repeat while DB7 is set and the poll budget remains
   assign poll_again = !lcd_rs_q && sample_q[7] && (int'(polls_q) < MAX_POLLS);
`else
   assign poll_again = 1'b0;
`endif

   // Next-state, phase counter and registered-output computation
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      sample_d       = sample_q;
      lcd_rs_d       = lcd_rs_q;
      rd_data_d      = rd_data_q;
      rd_busy_flag_d = rd_busy_flag_q;
      rd_addr_d      = rd_addr_q;
      rd_timeout_d   = rd_timeout_q;
`ifdef LCD_READER_BUSY_POLL_EN
      polls_d        = polls_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (rd_req && rd_ready_q) begin
               state_d  = S_SETUP;
               cnt_d    = LD_SETUP;
               lcd_rs_d = rd_rs;
`ifdef LCD_READER_BUSY_POLL_EN
               polls_d  = PW'(1);
`endif
            end
         end
         S_SETUP: begin
            if (cnt_q == '0) begin
               state_d = S_EN_HIGH;
               cnt_d   = LD_EN_HIGH;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_EN_HIGH: begin
            if (cnt_q == '0) begin
               // Capture the bus on the edge that also drops EN
               state_d  = S_HOLD;
               cnt_d    = LD_EN_LOW;
               sample_d = lcd_data_in;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_HOLD: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (poll_again) begin
               state_d = S_SETUP;
               cnt_d   = LD_SETUP;
`ifdef LCD_READER_BUSY_POLL_EN
               polls_d = polls_q + 1'b1;
`endif
            end else begin
               state_d        = S_DONE;
               rd_data_d      = sample_q;
               rd_busy_flag_d = !lcd_rs_q && sample_q[7];
               rd_addr_d      = lcd_rs_q ? 7'd0 : sample_q[6:0];
`ifdef LCD_READER_BUSY_POLL_EN
               rd_timeout_d   = !lcd_rs_q && sample_q[7];
`else
               rd_timeout_d   = 1'b0;
`endif
            end
         end
         S_DONE: begin
            state_d  = S_IDLE;
            lcd_rs_d = 1'b0;
         end
         default: begin
            state_d  = S_IDLE;
            lcd_rs_d = 1'b0;
         end
      endcase
      // Bus and handshake outputs follow the next state so they are registered
      lcd_en_d      = (state_d == S_EN_HIGH);
      lcd_rw_d      = (state_d != S_IDLE);
      lcd_data_oe_d = !lcd_rw_d;
      rd_ready_d    = (state_d == S_IDLE);
      rd_valid_d    = (state_d == S_DONE);
   end

   // State and output registers; reset drops EN immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         sample_q       <= 8'd0;
         lcd_en_q       <= 1'b0;
         lcd_rw_q       <= 1'b0;
         lcd_rs_q       <= 1'b0;
         lcd_data_oe_q  <= 1'b1;
         rd_ready_q     <= 1'b1;
         rd_valid_q     <= 1'b0;
         rd_data_q      <= 8'd0;
         rd_busy_flag_q <= 1'b0;
         rd_addr_q      <= 7'd0;
         rd_timeout_q   <= 1'b0;
`ifdef LCD_READER_BUSY_POLL_EN
         polls_q        <= '0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         sample_q       <= sample_d;
         lcd_en_q       <= lcd_en_d;
         lcd_rw_q       <= lcd_rw_d;
         lcd_rs_q       <= lcd_rs_d;
         lcd_data_oe_q  <= lcd_data_oe_d;
         rd_ready_q     <= rd_ready_d;
         rd_valid_q     <= rd_valid_d;
         rd_data_q      <= rd_data_d;
         rd_busy_flag_q <= rd_busy_flag_d;
         rd_addr_q      <= rd_addr_d;
         rd_timeout_q   <= rd_timeout_d;
`ifdef LCD_READER_BUSY_POLL_EN
         polls_q        <= polls_d;
`endif
      end
   end

   assign rd_ready     = rd_ready_q;
   assign rd_valid     = rd_valid_q;
   assign rd_data      = rd_data_q;
   assign rd_busy_flag = rd_busy_flag_q;
   assign rd_addr      = rd_addr_q;
   assign rd_timeout   = rd_timeout_q;
   assign lcd_en       = lcd_en_q;
   assign lcd_rw       = lcd_rw_q;
   assign lcd_rs       = lcd_rs_q;
   assign lcd_data_oe  = lcd_data_oe_q;

endmodule

// File: tb/tb_lcd_hd44780_reader.sv
// tb/tb_lcd_hd44780_reader.sv - directed self-checking bench for lcd_hd44780_reader
module tb_lcd_hd44780_reader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rd_req;
   logic       rd_rs;
   logic       rd_ready;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       rd_busy_flag;
   logic [6:0] rd_addr;
   logic       rd_timeout;
   logic       lcd_en;
   logic       lcd_rw;
   logic       lcd_rs;
   logic       lcd_data_oe;
   logic [7:0] lcd_data_in;

   logic [7:0] tb_data;
   logic [7:0] poll_data;
   bit         poll_mode = 1'b0;
   int         poll_busy = 0;
   int         pulse_no  = 0;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef LCD_READER_BUSY_POLL_EN
   localparam logic [7:0] INSTR_DATA = 8'h25;
   localparam logic       INSTR_BF   = 1'b0;
   localparam logic [6:0] INSTR_ADDR = 7'h25;
`else
   localparam logic [7:0] INSTR_DATA = 8'h85;
   localparam logic       INSTR_BF   = 1'b1;
   localparam logic [6:0] INSTR_ADDR = 7'h05;
`endif

   always #5 clk = ~clk;

   assign lcd_data_in = poll_mode ? poll_data : tb_data;

   // LCD model for polling: busy for poll_busy reads, then address 0x03
   always @(posedge lcd_en) begin
      if (poll_mode) begin
         pulse_no  = pulse_no + 1;
         poll_data = (pulse_no <= poll_busy) ? 8'h80 : 8'h03;
      end
   end

`ifdef LCD_READER_BUSY_POLL_EN
   lcd_hd44780_reader #(.T_SETUP(3), .T_EN_HIGH(15), .T_EN_LOW(15), .MAX_POLLS(5)) dut (
`else
   lcd_hd44780_reader #(.T_SETUP(3), .T_EN_HIGH(15), .T_EN_LOW(15), .MAX_POLLS(1000)) dut (
`endif
      .clk          (clk),
      .rst_n        (rst_n),
      .rd_req       (rd_req),
      .rd_rs        (rd_rs),
      .rd_ready     (rd_ready),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .rd_busy_flag (rd_busy_flag),
      .rd_addr      (rd_addr),
      .rd_timeout   (rd_timeout),
      .lcd_en       (lcd_en),
      .lcd_rw       (lcd_rw),
      .lcd_rs       (lcd_rs),
      .lcd_data_oe  (lcd_data_oe),
      .lcd_data_in  (lcd_data_in)
   );

   // Issues one request and records what the bus and result ports did.
   // n counts negedges after the accept edge; rd_valid is expected at n=33
   // (cycle 34 when the accept cycle is numbered 0).
   task automatic run_read(input bit rs, input bit swap, input bit poke, input int bound,
                           output int lat, output int en_first, output int en_len,
                           output int pulses, output bit rw_ok, output bit rs_ok,
                           output bit oe_ok, output logic [7:0] v_data, output logic v_bf,
                           output logic [6:0] v_addr, output logic v_to,
                           output int extra, output logic post_rw, output logic post_ready);
      bit prev_en;
      lat = -1; en_first = -1; en_len = 0; pulses = 0; extra = 0;
      rw_ok = 1'b1; rs_ok = 1'b1; oe_ok = 1'b1; prev_en = 1'b0;
      v_data = 8'h00; v_bf = 1'b0; v_addr = 7'h00; v_to = 1'b0;
      post_rw = 1'bx; post_ready = 1'bx;
      @(negedge clk);
      rd_req = 1'b1;
      rd_rs  = rs;
      @(posedge clk);
      for (int n = 0; n < bound; n++) begin
         @(negedge clk);
         rd_req = poke && (n == 4 || n == 33);
         rd_rs  = ~rs;
         if (lcd_en === 1'b1) begin
            en_len++;
            if (!prev_en) begin
               pulses++;
               if (en_first < 0) en_first = n;
            end
         end
         if (lcd_en !== 1'b1 && prev_en && swap) tb_data = 8'hFF;
         if (lcd_rw !== 1'b1) rw_ok = 1'b0;
         if (lcd_data_oe !== 1'b0) oe_ok = 1'b0;
         if (lcd_rs !== rs) rs_ok = 1'b0;
         prev_en = (lcd_en === 1'b1);
         if (rd_valid === 1'b1) begin
            lat = n; v_data = rd_data; v_bf = rd_busy_flag; v_addr = rd_addr; v_to = rd_timeout;
            break;
         end
      end
      for (int m = 0; m < 50; m++) begin
         @(negedge clk);
         rd_req = 1'b0;
         if (m == 0) begin
            post_rw = lcd_rw;
            post_ready = rd_ready;
         end
         if (rd_valid === 1'b1 || lcd_en === 1'b1) extra++;
      end
   endtask

   int lat, en_first, en_len, pulses, extra;
   bit rw_ok, rs_ok, oe_ok;
   logic [7:0] v_data;
   logic v_bf, v_to, post_rw, post_ready;
   logic [6:0] v_addr;

   task automatic test_reset();
      rst_n = 1'b0; rd_req = 1'b0; rd_rs = 1'b0; tb_data = 8'h00;
      repeat (3) @(negedge clk);
      n_checks++; if (lcd_en !== 1'b0) begin n_fail++; $display("FAIL reset_lcd_en: got %b expected 0", lcd_en); end
      n_checks++; if (lcd_rw !== 1'b0) begin n_fail++; $display("FAIL reset_lcd_rw: got %b expected 0", lcd_rw); end
      n_checks++; if (lcd_rs !== 1'b0) begin n_fail++; $display("FAIL reset_lcd_rs: got %b expected 0", lcd_rs); end
      n_checks++; if (lcd_data_oe !== 1'b1) begin n_fail++; $display("FAIL reset_oe: got %b expected 1", lcd_data_oe); end
      n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rd_valid); end
      n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rd_data); end
      n_checks++; if (rd_busy_flag !== 1'b0) begin n_fail++; $display("FAIL reset_bf: got %b expected 0", rd_busy_flag); end
      n_checks++; if (rd_addr !== 7'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", rd_addr); end
      n_checks++; if (rd_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", rd_timeout); end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", rd_ready); end
   endtask

   task automatic test_instr_read();
      tb_data = INSTR_DATA;
      run_read(1'b0, 1'b0, 1'b0, 100, lat, en_first, en_len, pulses, rw_ok, rs_ok, oe_ok,
               v_data, v_bf, v_addr, v_to, extra, post_rw, post_ready);
      n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL instr_latency: got %0d expected 33", lat); end
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL instr_pulses: got %0d expected 1", pulses); end
      n_checks++; if (v_data !== INSTR_DATA) begin n_fail++; $display("FAIL instr_data: got %h expected %h", v_data, INSTR_DATA); end
      n_checks++; if (v_bf !== INSTR_BF) begin n_fail++; $display("FAIL instr_bf: got %b expected %b", v_bf, INSTR_BF); end
      n_checks++; if (v_addr !== INSTR_ADDR) begin n_fail++; $display("FAIL instr_addr: got %h expected %h", v_addr, INSTR_ADDR); end
      n_checks++; if (v_to !== 1'b0) begin n_fail++; $display("FAIL instr_timeout: got %b expected 0", v_to); end
      n_checks++; if (rs_ok !== 1'b1) begin n_fail++; $display("FAIL instr_lcd_rs_held: got %b expected 1", rs_ok); end
      n_checks++; if (rw_ok !== 1'b1) begin n_fail++; $display("FAIL instr_lcd_rw_held: got %b expected 1", rw_ok); end
      n_checks++; if (post_rw !== 1'b0) begin n_fail++; $display("FAIL instr_rw_after: got %b expected 0", post_rw); end
      n_checks++; if (post_ready !== 1'b1) begin n_fail++; $display("FAIL instr_ready_after: got %b expected 1", post_ready); end
      n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL instr_extra_activity: got %0d expected 0", extra); end
   endtask

   task automatic test_data_read();
      tb_data = 8'h41;
      run_read(1'b1, 1'b0, 1'b0, 100, lat, en_first, en_len, pulses, rw_ok, rs_ok, oe_ok,
               v_data, v_bf, v_addr, v_to, extra, post_rw, post_ready);
      n_checks++; if (v_data !== 8'h41) begin n_fail++; $display("FAIL data_data: got %h expected 41", v_data); end
      n_checks++; if (v_bf !== 1'b0) begin n_fail++; $display("FAIL data_bf: got %b expected 0", v_bf); end
      n_checks++; if (v_addr !== 7'h00) begin n_fail++; $display("FAIL data_addr: got %h expected 00", v_addr); end
      n_checks++; if (rs_ok !== 1'b1) begin n_fail++; $display("FAIL data_lcd_rs_high: got %b expected 1", rs_ok); end
      n_checks++; if (oe_ok !== 1'b1) begin n_fail++; $display("FAIL data_oe_low: got %b expected 1", oe_ok); end
      n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL data_latency: got %0d expected 33", lat); end
   endtask

   task automatic test_timing();
      tb_data = 8'h5A;
      run_read(1'b1, 1'b1, 1'b0, 100, lat, en_first, en_len, pulses, rw_ok, rs_ok, oe_ok,
               v_data, v_bf, v_addr, v_to, extra, post_rw, post_ready);
      n_checks++; if (en_first !== 3) begin n_fail++; $display("FAIL timing_setup: got %0d expected 3", en_first); end
      n_checks++; if (en_len !== 15) begin n_fail++; $display("FAIL timing_en_high: got %0d expected 15", en_len); end
      n_checks++; if (v_data !== 8'h5A) begin n_fail++; $display("FAIL timing_sample: got %h expected 5a", v_data); end
      n_checks++; if (rw_ok !== 1'b1) begin n_fail++; $display("FAIL timing_rw_stable: got %b expected 1", rw_ok); end
   endtask

   task automatic test_ignored_req();
      tb_data = 8'h33;
      run_read(1'b1, 1'b0, 1'b1, 100, lat, en_first, en_len, pulses, rw_ok, rs_ok, oe_ok,
               v_data, v_bf, v_addr, v_to, extra, post_rw, post_ready);
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL ignored_pulses: got %0d expected 1", pulses); end
      n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL ignored_latency: got %0d expected 33", lat); end
      n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ignored_extra: got %0d expected 0", extra); end
      n_checks++; if (v_data !== 8'h33) begin n_fail++; $display("FAIL ignored_data: got %h expected 33", v_data); end
   endtask

   task automatic test_back_to_back();
      int first_v, second_v;
      logic [7:0] second_data;
      first_v = -1; second_v = -1; second_data = 8'h00;
      tb_data = 8'h11;
      @(negedge clk);
      rd_req = 1'b1; rd_rs = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (rd_valid === 1'b1) begin
            if (first_v < 0) begin
               first_v = c;
               tb_data = 8'h22;
            end else begin
               second_v = c;
               second_data = rd_data;
               rd_req = 1'b0;
               break;
            end
         end
      end
      rd_req = 1'b0;
      repeat (40) @(negedge clk);
      n_checks++; if (second_v - first_v !== 35 || first_v < 0) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 35", second_v - first_v); end
      n_checks++; if (second_data !== 8'h22) begin n_fail++; $display("FAIL b2b_second_data: got %h expected 22", second_data); end
   endtask

   task automatic test_reset_mid();
      int act;
      act = 0;
      tb_data = 8'h77;
      @(negedge clk);
      rd_req = 1'b1; rd_rs = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rd_req = 1'b0;
      repeat (9) @(negedge clk);
      n_checks++; if (lcd_en !== 1'b1) begin n_fail++; $display("FAIL mid_en_before: got %b expected 1", lcd_en); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (lcd_en !== 1'b0) begin n_fail++; $display("FAIL mid_en_async: got %b expected 0", lcd_en); end
      n_checks++; if (lcd_rw !== 1'b0) begin n_fail++; $display("FAIL mid_rw_async: got %b expected 0", lcd_rw); end
      n_checks++; if (lcd_data_oe !== 1'b1) begin n_fail++; $display("FAIL mid_oe_async: got %b expected 1", lcd_data_oe); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b expected 1", rd_ready); end
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (rd_valid === 1'b1 || lcd_en === 1'b1) act++;
      end
      n_checks++; if (act !== 0) begin n_fail++; $display("FAIL mid_no_valid: got %0d expected 0", act); end
   endtask

`ifdef LCD_READER_BUSY_POLL_EN
   task automatic test_busy_poll();
      poll_mode = 1'b1; poll_busy = 3; pulse_no = 0; poll_data = 8'h80;
      run_read(1'b0, 1'b0, 1'b0, 400, lat, en_first, en_len, pulses, rw_ok, rs_ok, oe_ok,
               v_data, v_bf, v_addr, v_to, extra, post_rw, post_ready);
      n_checks++; if (pulses !== 4) begin n_fail++; $display("FAIL poll_pulses: got %0d expected 4", pulses); end
      n_checks++; if (v_addr !== 7'h03) begin n_fail++; $display("FAIL poll_addr: got %h expected 03", v_addr); end
      n_checks++; if (v_to !== 1'b0) begin n_fail++; $display("FAIL poll_timeout: got %b expected 0", v_to); end
      n_checks++; if (lat !== 132) begin n_fail++; $display("FAIL poll_latency: got %0d expected 132", lat); end
      n_checks++; if (rw_ok !== 1'b1 || rs_ok !== 1'b1) begin n_fail++; $display("FAIL poll_rw_rs_held: got %b%b expected 11", rw_ok, rs_ok); end
      poll_mode = 1'b0;
   endtask

   task automatic test_poll_timeout();
      poll_mode = 1'b1; poll_busy = 1000; pulse_no = 0; poll_data = 8'h80;
      run_read(1'b0, 1'b0, 1'b0, 400, lat, en_first, en_len, pulses, rw_ok, rs_ok, oe_ok,
               v_data, v_bf, v_addr, v_to, extra, post_rw, post_ready);
      n_checks++; if (pulses !== 5) begin n_fail++; $display("FAIL pto_pulses: got %0d expected 5", pulses); end
      n_checks++; if (v_to !== 1'b1) begin n_fail++; $display("FAIL pto_timeout: got %b expected 1", v_to); end
      n_checks++; if (v_bf !== 1'b1) begin n_fail++; $display("FAIL pto_bf: got %b expected 1", v_bf); end
      n_checks++; if (lat !== 165) begin n_fail++; $display("FAIL pto_latency: got %0d expected 165", lat); end
      poll_mode = 1'b0;
   endtask
`endif

   initial begin
      rst_n = 1'b0; rd_req = 1'b0; rd_rs = 1'b0; tb_data = 8'h00; poll_data = 8'h00;
      test_reset();
      test_instr_read();
      test_data_read();
      test_timing();
      test_ignored_req();
      test_back_to_back();
      test_reset_mid();
`ifdef LCD_READER_BUSY_POLL_EN
      test_busy_poll();
      test_poll_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_hd44780_reader.md
Name: lcd_hd44780_reader

Overview:
- Read-side engine for the 8-bit HD44780 character LCD bus; the counterpart to the instruction/data writer that drives EN/RW/RS/data.
- On request, runs one bus read cycle (RW=1) and returns the sampled byte.
  - RS=0: busy flag plus address counter.
  - RS=1: DDRAM/CGRAM data.
- Sits between the LCD sequencer and the top-level pad tristate, sharing lcd_en/lcd_rs/lcd_rw with the writer through a top-level mux.

Parameters:
- T_SETUP, 3, clk cycles RS/RW held stable before EN rises (≥40 ns at 50 MHz).
- T_EN_HIGH, 15, clk cycles EN held high (≥230 ns; data sampled on last cycle).
- T_EN_LOW, 15, clk cycles EN low after the pulse before completion (EN cycle ≥500 ns).
- MAX_POLLS, 1000, maximum busy-flag reads per request (used only with the optional feature).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req  in  1  read request; accepted only when rd_req && rd_ready.
- rd_rs  in  1  register select for the request (0 = instruction/busy, 1 = data); latched on accept.
- rd_ready  out  1  high only in IDLE.
- rd_valid  out  1  one-cycle pulse; result fields are valid in that cycle.
- rd_data  out  8  sampled byte; held until the next rd_valid.
- rd_busy_flag  out  1  rd_data[7] when the latched rs = 0, else 0.
- rd_addr  out  7  rd_data[6:0] when the latched rs = 0, else 0.
- rd_timeout  out  1  valid with rd_valid; busy never cleared (optional feature only).
- lcd_en  out  1  LCD enable strobe.
- lcd_rw  out  1  LCD read/write select; 1 during a transaction.
- lcd_rs  out  1  LCD register select.
- lcd_data_oe  out  1  pad output enable = !lcd_rw; low for the whole transaction.
- lcd_data_in  in  8  LCD DB7..DB0 from the pads.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - lcd_en=0, lcd_rw=0, lcd_rs=0, lcd_data_oe=1.
  - rd_valid=0, rd_data=0, rd_busy_flag=0, rd_addr=0, rd_timeout=0, rd_ready=1 after release.
  - All outputs are registered.
- States: IDLE -> SETUP -> EN_HIGH -> HOLD -> DONE -> IDLE. A single down-counter times every state.
- IDLE:
  - Accept on edge k: latch rd_rs, go to SETUP.
  - Set lcd_rw=1 and lcd_rs=rs at edge k.
- SETUP: cycles k+1..k+T_SETUP; lcd_en=0.
- EN_HIGH: next T_EN_HIGH cycles; lcd_en=1.
  - lcd_data_in is registered on the edge that ends the last EN_HIGH cycle, before EN falls.
- HOLD: next T_EN_LOW cycles; lcd_en=0; lcd_rw and lcd_rs unchanged.
- DONE: one cycle.
  - rd_valid=1; result fields update.
  - lcd_rw returns to 0 on exit.
- Latency: rd_valid high in cycle k+T_SETUP+T_EN_HIGH+T_EN_LOW+1, i.e. k+34 at defaults. Throughput is one read per 35 cycles.
- Request rules:
  - rd_req while rd_ready=0 (including the DONE cycle) is ignored, not queued.
  - rd_rs is ignored outside the accept cycle.
- lcd_rs and lcd_rw never change while lcd_en=1.
- Reset mid-transaction: lcd_en falls immediately; no rd_valid is produced for the aborted read.
- All T_* parameters must be ≥1. Counter width is sized by $clog2 of the largest parameter.

Optional Feature:
- Macro: LCD_READER_BUSY_POLL_EN.
- Enabled, for an rs=0 request:
  - At the end of HOLD, if the sampled DB7=1 and reads < MAX_POLLS, return to SETUP and issue another read. lcd_rw stays 1 and lcd_rs stays 0 throughout.
  - Otherwise go to DONE.
  - rd_timeout=1 in the DONE cycle if the final sample had DB7=1 after MAX_POLLS reads, else 0.
  - rs=1 requests behave as single reads.
- Disabled: every request is exactly one read; rd_timeout is tied 0; MAX_POLLS is unused.

Test Plan:
- Instruction read: lcd_data_in=0x85, rd_req/rd_rs=0 accepted at cycle 0 -> one EN pulse; rd_valid at cycle 34; rd_data=0x85, rd_busy_flag=1, rd_addr=0x05.
- Data read: rd_rs=1, lcd_data_in=0x41 -> rd_data=0x41, rd_busy_flag=0, rd_addr=0; lcd_rs=1 during transaction; lcd_data_oe=0 throughout.
- Timing check: RS/RW stable 3 cycles before EN rises; EN high exactly 15 cycles; lcd_data_in changed to 0xFF on the cycle after EN falls -> rd_data holds the pre-fall value.
- rd_req pulsed at cycles 5 and 34 (busy, DONE) -> both ignored; exactly one rd_valid.
- rst_n low at cycle 10 (EN high) -> lcd_en=0 and lcd_rw=0 asynchronously; rd_ready=1 after release; no rd_valid.
- With LCD_READER_BUSY_POLL_EN: DB7=1 for 3 reads, then 0x03 -> 4 EN pulses, rd_addr=0x03, rd_timeout=0. With MAX_POLLS=5 and DB7 stuck at 1 -> 5 pulses, rd_timeout=1.
